// File: rtl/hack_pkg.sv
// Shared widths and decode helper for the 64-word RAM.
// Banks are RAM8 blocks of eight words; the top address bits pick the bank.
package hack_pkg;

    localparam int WORD_W      = 16;
    localparam int RAM8_ADDR_W = 3;
    localparam int BANK_SEL_W  = 3;
    localparam int RAM8_WORDS  = 1 << RAM8_ADDR_W;
    localparam int NUM_BANKS   = 1 << BANK_SEL_W;

    // One-hot 1-to-8 demux: at most one output bit is ever set.
    function automatic logic [7:0] demux8(
        input logic [2:0] sel,
        input logic       en
    );
        logic [7:0] res;
        res      = '0;
        res[sel] = en;
        return res;
    endfunction

endpackage

// File: rtl/ram8.sv
// Eight-word register bank with synchronous active-low clear,
// one-hot per-word write enables and a combinational read mux.
module ram8
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out
);

    logic [WIDTH-1:0]      words [RAM8_WORDS];
    logic [RAM8_WORDS-1:0] word_load;

    assign word_load = demux8(address, load);

    for (genvar w = 0; w < RAM8_WORDS; w++) begin : g_word
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                words[w] <= '0;
            end else if (word_load[w]) begin
                words[w] <= in;
            end
        end
    end

    // Read shows the stored value, so a same-cycle write is seen next cycle.
    assign out = words[address];

endmodule

// File: rtl/ram64.sv
// 64-word RAM built from eight RAM8 banks: bank-level load demux on the
// upper address bits, word-level handling inside each bank, bank read mux.
module ram64
    import hack_pkg::*;
#(
    parameter int WORD_W = hack_pkg::WORD_W,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WORD_W-1:0] out
);

    logic [BANK_SEL_W-1:0]  bank_sel;
    logic [RAM8_ADDR_W-1:0] word_sel;
    logic [NUM_BANKS-1:0]   bank_load;
    logic [WORD_W-1:0]      bank_out [NUM_BANKS];

    assign bank_sel  = address[ADDR_W-1 -: BANK_SEL_W];
    assign word_sel  = address[RAM8_ADDR_W-1:0];
    assign bank_load = demux8(bank_sel, load);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram8 #(
            .WIDTH(WORD_W)
        ) u_ram8 (
            .clk    (clk),
            .rst_n  (rst_n),
            .in     (in),
            .load   (bank_load[b]),
            .address(word_sel),
            .out    (bank_out[b])
        );
    end

    assign out = bank_out[bank_sel];

endmodule

// File: doc/ram64.md
RAM64 -- requirements
Module: ram64

Interface
REQ-001 The block SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port: rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port: in  input  16  write data word.
REQ-004 The block SHALL have port: load  input  1  write enable for the word at address.
REQ-005 The block SHALL have port: address  input  6  word select; [5:3] is the bank, [2:0] is the word within the bank.
REQ-006 The block SHALL have port: out  output  16  read data word.
REQ-007 The block SHALL have parameter: WORD_W, default 16, word width.
REQ-008 The block SHALL have parameter: ADDR_W, default 6, address width, which fixes the depth at 64 words.

Function
REQ-009 Storage SHALL be 64 words of WORD_W bits, organised as 8 banks of 8 words.
REQ-010 out SHALL equal the current stored content of the word selected by address, combinationally, with 0-cycle read latency and no clock needed.
REQ-011 On a rising clk edge with rst_n=1 and load=1, the word at address SHALL take the value of in; all other 63 words SHALL hold.
REQ-012 On a rising clk edge with rst_n=1 and load=0, all words SHALL hold.
REQ-013 The write path SHALL steer load by a 1-to-8 demultiplex on address[5:3] into per-bank loads, then by a 1-to-8 demultiplex on address[2:0] into per-word loads; at most one per-word load SHALL be asserted in any cycle.
REQ-014 The read path SHALL be an 8-way word mux inside each bank (on address[2:0]) followed by an 8-way bank mux (on address[5:3]).
REQ-015 Read during write: in the cycle where load=1, out SHALL show the old content of the addressed word; the new value SHALL appear on out from the cycle after the edge while address is unchanged.
REQ-016 A change of address between edges SHALL change out within the same cycle and SHALL NOT alter any stored word.
REQ-017 Consecutive writes to the same address on back-to-back edges SHALL leave the last-written value; there is no write merging.
REQ-018 The boundary addresses 0 and 63 SHALL behave identically to every other address; there is no wrap or aliasing beyond 6 bits.

Reset
REQ-019 On a rising clk edge with rst_n=0, all 64 words SHALL clear to 0, so out reads 0 for every address from the next cycle.
REQ-020 rst_n=0 SHALL take priority over load=1 on the same edge, so the write is discarded.
REQ-021 Reset asserted between writes SHALL discard all earlier contents, with no partial retention.
REQ-022 The design SHALL have no asynchronous reset path; rst_n SHALL NOT appear in any sensitivity list except via clk.

Structure
REQ-023 A shared package hack_pkg SHALL hold WORD_W (16), RAM8_ADDR_W (3), and BANK_SEL_W (3).
REQ-024 There SHALL be one sub-module, ram8, with ports clk, rst_n, in[15:0], load, address[2:0], out[15:0], containing 8 word registers with the same reset, write and read rules.
REQ-025 ram64 SHALL instantiate ram8 eight times, and SHALL contain the bank-level load demux and the bank-level out mux.
REQ-026 The word registers SHALL be plain edge-triggered flops, with no latches and no memory inference attributes required.

Verification
REQ-027 The bench SHALL apply reset, then sweep address 0..63 with load=0; out SHALL be 0x0000 at every address.
REQ-028 The bench SHALL write 0x1234 to address 9 (load=1 for one edge), then read addresses 8, 9 and 10; out SHALL be 0x0000, 0x1234 and 0x0000 respectively.
REQ-029 The bench SHALL write value 0xA500|addr to all 64 addresses, then read them back; each address SHALL return its own value, and address 63 SHALL return 0xA53F.
REQ-030 The bench SHALL hold address=5 with in=0xBEEF and load=1; out SHALL be the old value (0x0000) before the edge and 0xBEEF after the edge.
REQ-031 The bench SHALL assert rst_n=0 and load=1 with in=0xFFFF at address 40 on the same edge; address 40 SHALL read 0x0000 afterwards.
REQ-032 After a fill, the bench SHALL pulse rst_n=0 for one edge; every address SHALL read 0x0000, and a subsequent write of 0x0001 to address 0 SHALL read back 0x0001.
